pb_slink_txn_arb: RTL and testbench

PB_SLINK_TXN_ARB -- requirements
Module: pb_slink_txn_arb

---
 rtl/picobello_pkg.sv | 14 +
 rtl/pb_rr_pick.sv | 28 ++
 rtl/pb_slink_txn_arb.sv | 125 ++++++++++++
 tb/tb_pb_slink_txn_arb.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/picobello_pkg.sv
// Shared types for the serial-link transaction arbiter.
package picobello_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StCmd,
    StBusy
  } arb_state_e;

  // Read beat counter is one bit wider than the AXI len field.
  localparam int unsigned BeatCntW = 9;

endpackage

// File: rtl/pb_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping.
module pb_rr_pick #(
  parameter int unsigned NumReq = 4,
  localparam int unsigned IdxW = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [IdxW-1:0]   idx_o,
  output logic              valid_o
);

  int unsigned w_cand;

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    w_cand  = 0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      w_cand = 32'(ptr_i) + i;
      if (w_cand >= NumReq) w_cand = w_cand - NumReq;
      if (!valid_o && req_i[IdxW'(w_cand)]) begin
        valid_o = 1'b1;
        idx_o   = IdxW'(w_cand);
      end
    end
  end

endmodule

// File: rtl/pb_slink_txn_arb.sv
// Transaction-atomic round-robin arbiter for the serial-link AXI master port.
module pb_slink_txn_arb
  import picobello_pkg::*;
#(
  parameter int unsigned NumReq        = 4,
  parameter int unsigned TimeoutCycles = 4096,
  localparam int unsigned IdxW = $clog2(NumReq),
  localparam int unsigned ToW  = $clog2(TimeoutCycles)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumReq-1:0]      req_i,
  output logic [NumReq-1:0]      gnt_o,
  input  logic [NumReq-1:0]      cmd_valid_i,
  input  logic [NumReq-1:0]      cmd_write_i,
  input  logic [NumReq-1:0][7:0] cmd_len_i,
  output logic [NumReq-1:0]      cmd_ready_o,
  output logic                   mst_cmd_valid_o,
  input  logic                   mst_cmd_ready_i,
  output logic                   mst_cmd_write_o,
  output logic [7:0]             mst_cmd_len_o,
  input  logic                   mst_beat_i,
  input  logic                   mst_bresp_i,
  output logic [IdxW-1:0]        owner_o,
  output logic                   busy_o,
  output logic                   timeout_o
);

  arb_state_e            r_state, w_state_next;
  logic [IdxW-1:0]       r_owner, r_ptr;
  logic                  r_write;
  logic [7:0]            r_len;
  logic [BeatCntW-1:0]   r_beat_cnt;
  logic [ToW-1:0]        r_to_cnt;

  logic [IdxW-1:0]       w_pick_idx;
  logic                  w_pick_valid;
  logic                  w_release;
  logic                  w_timeout;
  logic                  w_cmd_fire;

  pb_rr_pick #(
    .NumReq (NumReq)
  ) u_rr_pick (
    .req_i   (req_i),
    .ptr_i   (r_ptr),
    .idx_o   (w_pick_idx),
    .valid_o (w_pick_valid)
  );

  always_comb begin
    w_state_next    = r_state;
    gnt_o           = '0;
    cmd_ready_o     = '0;
    mst_cmd_valid_o = 1'b0;
    mst_cmd_write_o = 1'b0;
    mst_cmd_len_o   = '0;
    w_release       = 1'b0;
    w_timeout       = 1'b0;
    w_cmd_fire      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_pick_valid) w_state_next = StGrant;
      end
      StGrant: begin
        gnt_o[r_owner] = 1'b1;
        if (!req_i[r_owner])          w_state_next = StIdle;
        else if (cmd_valid_i[r_owner]) w_state_next = StCmd;
      end
      StCmd: begin
        gnt_o[r_owner]  = 1'b1;
        mst_cmd_valid_o = 1'b1;
        mst_cmd_write_o = cmd_write_i[r_owner];
        mst_cmd_len_o   = cmd_len_i[r_owner];
        if (mst_cmd_ready_i) begin
          cmd_ready_o[r_owner] = 1'b1;
          w_cmd_fire           = 1'b1;
          w_state_next         = StBusy;
        end
      end
      StBusy: begin
        gnt_o[r_owner] = 1'b1;
        w_timeout      = (r_to_cnt == ToW'(TimeoutCycles - 1));
        // Writes end on the B handshake; reads end on the last R beat.
        w_release      = w_timeout ||
                         (r_write ? mst_bresp_i
                                  : (mst_beat_i && (r_beat_cnt == BeatCntW'(r_len))));
        if (w_release) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign busy_o    = (r_state != StIdle);
  assign owner_o   = busy_o ? r_owner : '0;
  assign timeout_o = w_timeout;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= StIdle;
      r_owner    <= '0;
      r_ptr      <= '0;
      r_write    <= 1'b0;
      r_len      <= '0;
      r_beat_cnt <= '0;
      r_to_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == StIdle && w_pick_valid) r_owner <= w_pick_idx;
      if (w_cmd_fire) begin
        r_write    <= cmd_write_i[r_owner];
        r_len      <= cmd_len_i[r_owner];
        r_beat_cnt <= '0;
        r_to_cnt   <= '0;
      end else if (r_state == StBusy) begin
        if (mst_beat_i) r_beat_cnt <= r_beat_cnt + BeatCntW'(1);
        r_to_cnt <= r_to_cnt + ToW'(1);
      end
      if (w_release) begin
        r_ptr <= (r_owner == IdxW'(NumReq - 1)) ? '0 : r_owner + IdxW'(1);
      end
    end
  end

endmodule

// File: tb/tb_pb_slink_txn_arb.sv
// Directed bench for pb_slink_txn_arb with hand-computed expectations.
module tb_pb_slink_txn_arb;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic [3:0]      req_i;
  logic [3:0]      gnt_o;
  logic [3:0]      cmd_valid_i;
  logic [3:0]      cmd_write_i;
  logic [3:0][7:0] cmd_len_i;
  logic [3:0]      cmd_ready_o;
  logic            mst_cmd_valid_o;
  logic            mst_cmd_ready_i;
  logic            mst_cmd_write_o;
  logic [7:0]      mst_cmd_len_o;
  logic            mst_beat_i;
  logic            mst_bresp_i;
  logic [1:0]      owner_o;
  logic            busy_o;
  logic            timeout_o;

  int n_vec = 0;
  int n_err = 0;
  int pulses;
  int pulse_at;

  always #5 clk_i = ~clk_i;

  pb_slink_txn_arb #(
    .NumReq        (4),
    .TimeoutCycles (16)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .req_i           (req_i),
    .gnt_o           (gnt_o),
    .cmd_valid_i     (cmd_valid_i),
    .cmd_write_i     (cmd_write_i),
    .cmd_len_i       (cmd_len_i),
    .cmd_ready_o     (cmd_ready_o),
    .mst_cmd_valid_o (mst_cmd_valid_o),
    .mst_cmd_ready_i (mst_cmd_ready_i),
    .mst_cmd_write_o (mst_cmd_write_o),
    .mst_cmd_len_o   (mst_cmd_len_o),
    .mst_beat_i      (mst_beat_i),
    .mst_bresp_i     (mst_bresp_i),
    .owner_o         (owner_o),
    .busy_o          (busy_o),
    .timeout_o       (timeout_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    @(negedge clk_i);
  endtask

  initial begin
    rst_ni          = 1'b0;
    req_i           = '0;
    cmd_valid_i     = '0;
    cmd_write_i     = '0;
    cmd_len_i       = '0;
    mst_cmd_ready_i = 1'b0;
    mst_beat_i      = 1'b0;
    mst_bresp_i     = 1'b0;
    repeat (2) nxt();
    settle();
    chk("rst_busy", busy_o, 0);
    chk("rst_gnt", gnt_o, 0);
    chk("rst_mvalid", mst_cmd_valid_o, 0);
    chk("rst_owner", owner_o, 0);
    nxt();
    rst_ni = 1'b1;

    // Requesters 1 and 3 compete from ptr=0: 1 wins.
    req_i       = 4'b1010;
    cmd_valid_i = 4'b0010;
    settle();
    chk("idle_gnt", gnt_o, 0);
    nxt();
    settle();
    chk("g1_gnt", gnt_o, 4'b0010);
    chk("g1_owner", owner_o, 1);
    chk("g1_no_mvalid", mst_cmd_valid_o, 0);
    nxt();
    settle();
    chk("c1_mvalid", mst_cmd_valid_o, 1);
    chk("c1_ready_wait", cmd_ready_o, 0);
    nxt();
    mst_cmd_ready_i = 1'b1;
    settle();
    chk("c1_ready", cmd_ready_o, 4'b0010);
    chk("c1_len", mst_cmd_len_o, 0);
    nxt();
    mst_cmd_ready_i = 1'b0;
    cmd_valid_i     = '0;
    mst_beat_i      = 1'b1;
    settle();
    chk("b1_busy", busy_o, 1);
    chk("b1_mvalid", mst_cmd_valid_o, 0);
    nxt();
    mst_beat_i = 1'b0;
    settle();
    chk("r1_gnt", gnt_o, 0);
    chk("r1_busy", busy_o, 0);
    nxt();
    settle();
    chk("g3_gnt", gnt_o, 4'b1000);
    chk("g3_owner", owner_o, 3);

    // Owner 3 drops its request in GRANT.
    req_i = '0;
    settle();
    chk("g3_no_mvalid", mst_cmd_valid_o, 0);
    nxt();
    settle();
    chk("drop_busy", busy_o, 0);
    chk("drop_gnt", gnt_o, 0);
    chk("drop_mvalid", mst_cmd_valid_o, 0);
    req_i = 4'b1001;
    nxt();
    settle();
    chk("ptr_kept_owner", owner_o, 3);
    cmd_valid_i     = 4'b1000;
    mst_cmd_ready_i = 1'b1;
    nxt();
    settle();
    chk("c3_ready", cmd_ready_o, 4'b1000);
    nxt();
    mst_cmd_ready_i = 1'b0;
    cmd_valid_i     = '0;
    mst_beat_i      = 1'b1;
    req_i           = 4'b0101;
    nxt();
    mst_beat_i = 1'b0;

    // Owner 0 read len=3: release on the 4th beat.
    nxt();
    settle();
    chk("g0_owner", owner_o, 0);
    chk("g0_gnt", gnt_o, 4'b0001);
    cmd_valid_i     = 4'b0001;
    cmd_len_i[0]    = 8'd3;
    mst_cmd_ready_i = 1'b1;
    nxt();
    settle();
    chk("c0_len", mst_cmd_len_o, 3);
    chk("c0_write", mst_cmd_write_o, 0);
    nxt();
    mst_cmd_ready_i = 1'b0;
    cmd_valid_i     = '0;
    mst_beat_i      = 1'b1;
    nxt();
    nxt();
    mst_beat_i = 1'b0;
    settle();
    chk("rd_gap_busy", busy_o, 1);
    nxt();
    mst_beat_i = 1'b1;
    settle();
    chk("rd_beat3_busy", busy_o, 1);
    nxt();
    settle();
    chk("rd_beat4_gnt", gnt_o, 4'b0001);
    nxt();
    mst_beat_i = 1'b0;
    req_i      = 4'b0100;
    settle();
    chk("rd_rel_gnt", gnt_o, 0);
    chk("rd_rel_busy", busy_o, 0);

    // Owner 2 write: a beat does not release, bresp does.
    nxt();
    settle();
    chk("g2_owner", owner_o, 2);
    cmd_valid_i     = 4'b0100;
    cmd_write_i     = 4'b0100;
    cmd_len_i[2]    = 8'd0;
    mst_cmd_ready_i = 1'b1;
    nxt();
    settle();
    chk("c2_write", mst_cmd_write_o, 1);
    nxt();
    mst_cmd_ready_i = 1'b0;
    cmd_valid_i     = '0;
    mst_beat_i      = 1'b1;
    nxt();
    mst_beat_i = 1'b0;
    settle();
    chk("wr_beat_busy", busy_o, 1);
    for (int i = 0; i < 3; i++) nxt();
    settle();
    chk("wr_wait_gnt", gnt_o, 4'b0100);
    nxt();
    mst_bresp_i = 1'b1;
    settle();
    chk("wr_bresp_gnt", gnt_o, 4'b0100);
    nxt();
    mst_bresp_i = 1'b0;
    req_i       = 4'b0010;
    settle();
    chk("wr_rel_busy", busy_o, 0);
    chk("wr_rel_gnt", gnt_o, 0);

    // Owner 1 read with no beats: forced release on the 16th BUSY cycle.
    nxt();
    settle();
    chk("g1b_owner", owner_o, 1);
    cmd_valid_i     = 4'b0010;
    cmd_write_i     = '0;
    cmd_len_i[1]    = 8'd5;
    mst_cmd_ready_i = 1'b1;
    nxt();
    nxt();
    mst_cmd_ready_i = 1'b0;
    cmd_valid_i     = '0;
    pulses          = 0;
    pulse_at        = 0;
    for (int i = 1; i <= 16; i++) begin
      settle();
      if (timeout_o === 1'b1) begin
        pulses++;
        pulse_at = i;
      end
      if (i < 16) nxt();
    end
    chk("to_pulses", pulses, 1);
    chk("to_cycle", pulse_at, 16);
    nxt();
    req_i = 4'b0001;
    settle();
    chk("to_after", timeout_o, 0);
    chk("to_gnt", gnt_o, 0);
    chk("to_busy", busy_o, 0);

    // Reset in the middle of a read burst.
    nxt();
    cmd_valid_i     = 4'b0001;
    cmd_len_i[0]    = 8'd7;
    mst_cmd_ready_i = 1'b1;
    nxt();
    nxt();
    mst_cmd_ready_i = 1'b0;
    cmd_valid_i     = '0;
    mst_beat_i      = 1'b1;
    nxt();
    nxt();
    mst_beat_i = 1'b0;
    settle();
    chk("pre_rst_busy", busy_o, 1);
    #2;
    rst_ni = 1'b0;
    req_i  = 4'b1000;
    #1;
    chk("arst_busy", busy_o, 0);
    chk("arst_gnt", gnt_o, 0);
    chk("arst_owner", owner_o, 0);
    chk("arst_mvalid", mst_cmd_valid_o, 0);
    chk("arst_cmdrdy", cmd_ready_o, 0);
    chk("arst_timeout", timeout_o, 0);
    chk("arst_mlen", mst_cmd_len_o, 0);
    nxt();
    nxt();
    rst_ni = 1'b1;
    nxt();
    settle();
    chk("post_rst_gnt", gnt_o, 4'b1000);
    chk("post_rst_owner", owner_o, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
